// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - sequencer-side and pin-side signals of the SDRAM command arbiter
interface sdram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 24
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              ref_req;
    logic              flag_ref_end;
    logic [3:0]        ref_cmd;
    logic [ADDR_W-1:0] ref_addr;
    logic              ref_en;

    logic              wr_req;
    logic              flag_wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BA_W-1:0]   wr_bank;
    logic [DQ_W-1:0]   wr_data;
    logic              wr_dq_oe;
    logic              wr_en;

    logic              rd_req;
    logic              flag_rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BA_W-1:0]   rd_bank;
    logic              rd_en;

    logic              sdram_cke;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_bank;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_req, flag_ref_end, ref_cmd, ref_addr,
        output ref_en,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data, wr_dq_oe,
        output wr_en,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output rd_en,
        output sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output ref_req, flag_ref_end, ref_cmd, ref_addr,
        input  ref_en,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data, wr_dq_oe,
        input  wr_en,
        output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  rd_en,
        input  sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares the SDRAM command bus between init, refresh, write and read sequencers
module sdram_arbiter #(
    parameter int         ADDR_W  = 13,
    parameter int         BA_W    = 2,
    parameter int         DQ_W    = 24,
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic            sclk,
    input  logic            s_rst,
    sdram_arbiter_if.slave  bus
);
    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_wr;
    logic   w_next_last_wr;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_state   <= S_INIT;
            r_last_wr <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_last_wr <= w_next_last_wr;
        end
    end

    // Refresh always wins; a write/read tie goes to whichever did not run last.
    always_comb begin
        w_next_state   = r_state;
        w_next_last_wr = r_last_wr;
        case (r_state)
            S_INIT: begin
                if (bus.init_end) w_next_state = S_ARBIT;
            end
            S_ARBIT: begin
                if (bus.ref_req)                    w_next_state = S_AREF;
                else if (bus.wr_req && bus.rd_req)  w_next_state = r_last_wr ? S_READ : S_WRITE;
                else if (bus.wr_req)                w_next_state = S_WRITE;
                else if (bus.rd_req)                w_next_state = S_READ;
            end
            S_AREF: begin
                if (bus.flag_ref_end) w_next_state = S_ARBIT;
            end
            S_WRITE: begin
                if (bus.flag_wr_end) begin
                    w_next_state   = S_ARBIT;
                    w_next_last_wr = 1'b1;
                end
            end
            S_READ: begin
                if (bus.flag_rd_end) begin
                    w_next_state   = S_ARBIT;
                    w_next_last_wr = 1'b0;
                end
            end
            default: w_next_state = S_INIT;
        endcase
    end

    // Pure decode of state so sequencer commands reach the pins in the same cycle.
    always_comb begin
        bus.ref_en       = 1'b0;
        bus.wr_en        = 1'b0;
        bus.rd_en        = 1'b0;
        bus.sdram_cke    = 1'b1;
        bus.sdram_cmd    = CMD_NOP;
        bus.sdram_addr   = {ADDR_W{1'b0}};
        bus.sdram_bank   = {BA_W{1'b0}};
        bus.sdram_dq_out = {DQ_W{1'b0}};
        bus.sdram_dq_oe  = 1'b0;
        if (!s_rst) begin
            case (r_state)
                S_INIT: begin
                    bus.sdram_cmd  = bus.init_cmd;
                    bus.sdram_addr = bus.init_addr;
                end
                S_AREF: begin
                    bus.ref_en     = 1'b1;
                    bus.sdram_cmd  = bus.ref_cmd;
                    bus.sdram_addr = bus.ref_addr;
                end
                S_WRITE: begin
                    bus.wr_en        = 1'b1;
                    bus.sdram_cmd    = bus.wr_cmd;
                    bus.sdram_addr   = bus.wr_addr;
                    bus.sdram_bank   = bus.wr_bank;
                    bus.sdram_dq_out = bus.wr_data;
                    bus.sdram_dq_oe  = bus.wr_dq_oe;
                end
                S_READ: begin
                    bus.rd_en      = 1'b1;
                    bus.sdram_cmd  = bus.rd_cmd;
                    bus.sdram_addr = bus.rd_addr;
                    bus.sdram_bank = bus.rd_bank;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed and randomized checks of sdram_arbiter against a bus-ownership model
module tb_sdram_arbiter;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 24;
    localparam logic [3:0] NOP = 4'b0111;

    logic sclk = 1'b0;
    logic s_rst;
    int   n_checks = 0;
    int   n_errors = 0;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W), .CMD_NOP(NOP)) dut (
        .sclk  (sclk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    function automatic logic [2:0] grants();
        return {bus.ref_en, bus.wr_en, bus.rd_en};
    endfunction

    task automatic clear_inputs();
        bus.init_end = 0; bus.init_cmd = 0; bus.init_addr = 0;
        bus.ref_req = 0; bus.flag_ref_end = 0; bus.ref_cmd = 0; bus.ref_addr = 0;
        bus.wr_req = 0; bus.flag_wr_end = 0; bus.wr_cmd = 0; bus.wr_addr = 0;
        bus.wr_bank = 0; bus.wr_data = 0; bus.wr_dq_oe = 0;
        bus.rd_req = 0; bus.flag_rd_end = 0; bus.rd_cmd = 0; bus.rd_addr = 0; bus.rd_bank = 0;
    endtask

    // Model: who currently owns the SDRAM bus and who was served last among write/read.
    typedef enum int {OWN_INIT, OWN_NONE, OWN_REF, OWN_WR, OWN_RD} owner_t;
    owner_t m_owner;
    owner_t m_next;
    bit     m_wr_served_last;
    bit     m_next_wr_last;

    function automatic logic [63:0] exp_pins();
        logic [3:0]        c = NOP;
        logic [ADDR_W-1:0] a = 0;
        logic [BA_W-1:0]   b = 0;
        logic [DQ_W-1:0]   d = 0;
        logic              oe = 0;
        if (!s_rst) begin
            if (m_owner == OWN_INIT) begin c = bus.init_cmd; a = bus.init_addr; end
            if (m_owner == OWN_REF)  begin c = bus.ref_cmd;  a = bus.ref_addr;  end
            if (m_owner == OWN_WR)   begin c = bus.wr_cmd; a = bus.wr_addr; b = bus.wr_bank;
                                           d = bus.wr_data; oe = bus.wr_dq_oe; end
            if (m_owner == OWN_RD)   begin c = bus.rd_cmd; a = bus.rd_addr; b = bus.rd_bank; end
        end
        return {20'd0, 1'b1, c, a, b, d, oe};
    endfunction

    function automatic logic [2:0] exp_grants();
        if (s_rst) return 3'b000;
        return {m_owner == OWN_REF, m_owner == OWN_WR, m_owner == OWN_RD};
    endfunction

    task automatic model_step();
        owner_t pick[$];
        m_next = m_owner;
        m_next_wr_last = m_wr_served_last;
        if (s_rst) begin
            m_next = OWN_INIT;
            m_next_wr_last = 0;
            return;
        end
        case (m_owner)
            OWN_INIT: if (bus.init_end) m_next = OWN_NONE;
            OWN_NONE: begin
                if (bus.ref_req) pick.push_back(OWN_REF);
                if (bus.wr_req && bus.rd_req)
                    pick.push_back(m_wr_served_last ? OWN_RD : OWN_WR);
                if (bus.wr_req) pick.push_back(OWN_WR);
                if (bus.rd_req) pick.push_back(OWN_RD);
                if (pick.size() > 0) m_next = pick[0];
            end
            OWN_REF: if (bus.flag_ref_end) m_next = OWN_NONE;
            OWN_WR:  if (bus.flag_wr_end) begin m_next = OWN_NONE; m_next_wr_last = 1; end
            OWN_RD:  if (bus.flag_rd_end) begin m_next = OWN_NONE; m_next_wr_last = 0; end
            default: m_next = OWN_INIT;
        endcase
    endtask

    function automatic logic [63:0] pins();
        return {20'd0, bus.sdram_cke, bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank,
                bus.sdram_dq_out, bus.sdram_dq_oe};
    endfunction

    initial begin
        int init_wait;
        string seq;
        clear_inputs();
        s_rst = 1;
        tick(); tick();
        check("rst_grants", grants(), 3'b000);
        check("rst_cmd", bus.sdram_cmd, NOP);
        check("rst_cke", bus.sdram_cke, 1'b1);
        check("rst_addr", bus.sdram_addr, 0);
        check("rst_dq_oe", bus.sdram_dq_oe, 0);

        // Init hold-off
        s_rst = 0; bus.init_cmd = 4'b0010; bus.init_addr = 13'h400;
        bus.ref_req = 1; bus.wr_req = 1; bus.rd_req = 1;
        repeat (100) tick();
        check("init_cmd", bus.sdram_cmd, 4'b0010);
        check("init_addr", bus.sdram_addr, 13'h400);
        check("init_grants", grants(), 3'b000);
        bus.ref_req = 0; bus.wr_req = 0; bus.rd_req = 0;
        bus.init_end = 1;
        tick();
        check("arbit_cmd", bus.sdram_cmd, NOP);
        check("arbit_addr", bus.sdram_addr, 0);

        // Refresh beats write
        bus.ref_req = 1; bus.wr_req = 1; bus.ref_cmd = 4'b0001; bus.ref_addr = 13'h0A0;
        tick();
        check("ref_grant", grants(), 3'b100);
        check("ref_cmd", bus.sdram_cmd, 4'b0001);
        bus.ref_req = 0; bus.flag_ref_end = 1;
        tick();
        bus.flag_ref_end = 0;
        check("post_ref_arbit", grants(), 3'b000);
        tick();
        check("wr_after_ref", grants(), 3'b010);

        // Write pin mux, stray read flag
        bus.wr_cmd = 4'b0100; bus.wr_addr = 13'h155; bus.wr_bank = 2;
        bus.wr_dq_oe = 1; bus.wr_data = 24'hA5A5A5;
        #1;
        check("wr_pins", pins(), {20'd0, 1'b1, 4'b0100, 13'h155, 2'd2, 24'hA5A5A5, 1'b1});
        bus.flag_rd_end = 1;
        tick();
        bus.flag_rd_end = 0;
        check("stray_rd_flag", grants(), 3'b010);

        // Read: dq_oe must stay low
        bus.flag_wr_end = 1; bus.wr_req = 0; bus.rd_req = 1;
        tick();
        bus.flag_wr_end = 0;
        tick();
        check("rd_grant", grants(), 3'b001);
        bus.rd_cmd = 4'b0101; bus.rd_addr = 13'h0F0; bus.rd_bank = 1;
        #1;
        check("rd_pins", pins(), {20'd0, 1'b1, 4'b0101, 13'h0F0, 2'd1, 24'd0, 1'b0});

        // Reset mid-read
        bus.init_cmd = NOP; bus.init_addr = 0;
        s_rst = 1;
        tick();
        s_rst = 0;
        #1;
        check("rst_mid_rd_grants", grants(), 3'b000);
        check("rst_mid_rd_cmd", bus.sdram_cmd, NOP);

        // Alternation with both requests held from reset
        clear_inputs();
        s_rst = 1; bus.init_end = 1; bus.wr_req = 1; bus.rd_req = 1;
        tick();
        s_rst = 0;
        tick();
        check("alt_arbit", grants(), 3'b000);
        seq = "";
        for (int g = 0; g < 4; g++) begin
            tick();
            seq = {seq, bus.wr_en ? "W" : (bus.rd_en ? "R" : "-")};
            bus.flag_wr_end = 1; bus.flag_rd_end = 1;
            tick();
            bus.flag_wr_end = 0; bus.flag_rd_end = 0;
            check("alt_gap", grants(), 3'b000);
        end
        check("alt_order", (seq == "WRWR") ? 64'd1 : 64'd0, 64'd1);

        // Randomized run against the ownership model
        clear_inputs();
        s_rst = 1;
        m_owner = OWN_INIT; m_wr_served_last = 0;
        init_wait = 5;
        for (int n = 0; n < 3000; n++) begin
            @(negedge sclk);
            s_rst = ($urandom_range(0, 299) == 0) || (n < 2);
            if (s_rst) init_wait = $urandom_range(0, 8);
            else if (init_wait > 0) init_wait--;
            bus.init_end = (init_wait == 0) && !s_rst;
            bus.init_cmd = 4'($urandom); bus.init_addr = 13'($urandom);
            bus.ref_req = ($urandom_range(0, 7) == 0);
            bus.wr_req = $urandom_range(0, 1); bus.rd_req = $urandom_range(0, 1);
            bus.flag_ref_end = ($urandom_range(0, 3) == 0);
            bus.flag_wr_end  = ($urandom_range(0, 3) == 0);
            bus.flag_rd_end  = ($urandom_range(0, 3) == 0);
            bus.ref_cmd = 4'($urandom); bus.ref_addr = 13'($urandom);
            bus.wr_cmd = 4'($urandom); bus.wr_addr = 13'($urandom); bus.wr_bank = 2'($urandom);
            bus.wr_data = 24'($urandom); bus.wr_dq_oe = $urandom_range(0, 1);
            bus.rd_cmd = 4'($urandom); bus.rd_addr = 13'($urandom); bus.rd_bank = 2'($urandom);
            #1;
            check("rand_grants", grants(), exp_grants());
            check("rand_pins", pins(), exp_pins());
            model_step();
            @(posedge sclk);
            m_owner = m_next;
            m_wr_served_last = m_next_wr_last;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Top-level SDRAM command scheduler; shares the single SDRAM command/address/data bus between the init, auto-refresh, write and read sequencers.
- Holds all requesters off until initialisation completes, then grants one requester at a time.
- Priority order: refresh > write/read. Write and read alternate when both are pending.
- Drives the SDRAM pins by muxing the granted sequencer's cmd/addr/bank/dq.

Parameters:
ADDR_W, 13, SDRAM address bus width
BA_W, 2, bank address width
DQ_W, 24, SDRAM data width
CMD_NOP, 4'b0111, NOP encoding {cs_n,ras_n,cas_n,we_n}

Ports:
sclk  in  1  system clock
s_rst  in  1  synchronous reset, active-high
init_end  in  1  init sequencer done (level, stays high)
init_cmd  in  4  init command
init_addr  in  ADDR_W  init address
ref_req  in  1  refresh request (level)
flag_ref_end  in  1  refresh burst done (1-cycle pulse)
ref_cmd  in  4  refresh command
ref_addr  in  ADDR_W  refresh address
ref_en  out  1  refresh grant
wr_req  in  1  write request (level)
flag_wr_end  in  1  write done (pulse)
wr_cmd  in  4  write command
wr_addr  in  ADDR_W  write address
wr_bank  in  BA_W  write bank
wr_data  in  DQ_W  write data
wr_dq_oe  in  1  write sequencer wants to drive dq
wr_en  out  1  write grant
rd_req  in  1  read request (level)
flag_rd_end  in  1  read done (pulse)
rd_cmd  in  4  read command
rd_addr  in  ADDR_W  read address
rd_bank  in  BA_W  read bank
rd_en  out  1  read grant
sdram_cke  out  1  clock enable
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
sdram_addr  out  ADDR_W  address pins
sdram_bank  out  BA_W  bank pins
sdram_dq_out  out  DQ_W  data to tristate buffer
sdram_dq_oe  out  1  dq output enable

Behaviour:
- States: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ. One-hot encoding; state register only.
- Reset (s_rst=1 at a sclk edge):
  - state=S_INIT; last_grant=READ.
  - All grant outputs 0; sdram_cmd=CMD_NOP; addr/bank/dq_out 0; dq_oe 0; sdram_cke 1.
  - Reset asserted mid-grant aborts immediately with no cleanup command.
- S_INIT: mux passes init_cmd/init_addr; bank 0. On init_end=1 go to S_ARBIT next cycle.
- S_ARBIT: cmd NOP, addr 0. Decision is evaluated in this cycle and takes effect next cycle:
  - ref_req → S_AREF.
  - else wr_req & rd_req → grant the one opposite last_grant.
  - else wr_req → S_WRITE.
  - else rd_req → S_READ.
  - else stay.
- S_AREF: ref_en=1; mux ref_cmd/ref_addr, bank 0. On flag_ref_end → S_ARBIT.
- S_WRITE: wr_en=1; mux wr_cmd/wr_addr/wr_bank; sdram_dq_out=wr_data; sdram_dq_oe=wr_dq_oe. On flag_wr_end → S_ARBIT and last_grant←WRITE.
- S_READ: rd_en=1; mux rd_cmd/rd_addr/rd_bank; dq_oe 0. On flag_rd_end → S_ARBIT and last_grant←READ.
- Grants and the output mux are combinational decodes of state, so commands pass through with zero added latency. Latency from request to grant is 1 cycle out of S_ARBIT.
- Every grant is followed by at least one S_ARBIT cycle, so a refresh pending at flag_*_end wins the next decision.
- In S_WRITE/S_READ, ref_req is not acted on by the arbiter. The active sequencer must observe ref_req itself and end with its flag.
- A flag_*_end not matching the current state is ignored.
- Outside S_WRITE, sdram_dq_oe=0 regardless of wr_dq_oe.
- A request dropped before the grant is simply not granted.

Test Plan:
- Reset then init_end held 0 for 100 cycles → state S_INIT; sdram_cmd follows init_cmd; all grants 0. Raise init_end → S_ARBIT 1 cycle later.
- ref_req=1 and wr_req=1 together in S_ARBIT → ref_en=1 next cycle, wr_en=0. After flag_ref_end, one ARBIT cycle, then wr_en=1.
- wr_req and rd_req both held high from reset → grants alternate W,R,W,R; first grant is write; exactly one ARBIT cycle between grants.
- In S_WRITE: wr_cmd=4'b0100, wr_addr=13'h155, wr_bank=2, wr_dq_oe=1, wr_data=24'hA5A5A5 → same values on the pins that cycle. In S_READ with wr_dq_oe=1 → sdram_dq_oe=0.
- flag_rd_end pulsed while in S_WRITE → ignored, state stays S_WRITE. s_rst asserted mid-S_READ → next cycle S_INIT, rd_en=0, cmd=4'b0111.
